// File: rtl/serv_alu_seq.sv
// serv_alu_seq: sequencer for the bit-serial ALU.
//
// Accepts one whole-word operation on a valid/ready command port. It then
// spends one cycle priming the ALU carry register, streams both operands
// LSB-first for N = XLEN/W beats while holding every ALU control input, and
// returns the collected result and compare flag on a valid/ready result port.
//
// Parameters:
//   W     ALU datapath width in bits per beat (XLEN must be a multiple of W)
//   XLEN  operand/result word width
//
// Ports:
//   clk, i_rst_n              clock (rising edge), async active-low reset
//   i_op_valid / o_op_ready   command handshake (ready only in IDLE)
//   i_op, i_rs1, i_op_b       opcode and operands, sampled on accept
//   o_res_valid / i_res_ready result handshake
//   o_res, o_res_cmp          result word and compare flag
//   o_alu_*                   ALU control and operand-beat outputs
//   i_alu_rd, i_alu_cmp       ALU result beat and compare output
//   i_abort                   only with SERV_ALU_SEQ_ABORT_EN defined:
//                             cancels an operation in PRIME or RUN
//
// Opcodes: 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 XOR, 5 OR, 6 AND, 7 EQ.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | ready for a command
// PRIME | ALU disabled for one cycle so its carry loads the carry-in
// RUN   | streaming N beats through the ALU
// DONE  | result presented, waiting for i_res_ready

module serv_alu_seq #(
    parameter int W    = 1,
    parameter int XLEN = 32
) (
`ifdef SERV_ALU_SEQ_ABORT_EN
    input  logic            i_abort,
`endif
    input  logic            clk,
    input  logic            i_rst_n,
    input  logic            i_op_valid,
    output logic            o_op_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_op_b,
    output logic            o_res_valid,
    input  logic            i_res_ready,
    output logic [XLEN-1:0] o_res,
    output logic            o_res_cmp,
    output logic            o_alu_en,
    output logic            o_alu_cnt0,
    output logic            o_alu_sub,
    output logic [1:0]      o_alu_bool_op,
    output logic            o_alu_cmp_eq,
    output logic            o_alu_cmp_sig,
    output logic [2:0]      o_alu_rd_sel,
    output logic [W-1:0]    o_alu_rs1,
    output logic [W-1:0]    o_alu_op_b,
    input  logic [W-1:0]    i_alu_rd,
    input  logic            i_alu_cmp
);

    localparam int N     = XLEN / W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_SLT  = 3'd2;
    localparam logic [2:0] OP_SLTU = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_AND  = 3'd6;
    localparam logic [2:0] OP_EQ   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   rs1_q;
    logic [XLEN-1:0]   op_b_q;
    logic [XLEN-1:0]   res_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              flag_q;
    logic              last_beat;
    logic              abort_w;
    logic              is_cmp;

`ifdef SERV_ALU_SEQ_ABORT_EN
    assign abort_w = i_abort;
`else
    assign abort_w = 1'b0;
`endif

    assign last_beat = (cnt_q == CNT_W'(N - 1));
    assign is_cmp    = (op_q == OP_SLT) || (op_q == OP_SLTU) || (op_q == OP_EQ);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_op_valid) state_d = S_PRIME;
            S_PRIME: state_d = S_RUN;
            S_RUN:   if (last_beat) state_d = S_DONE;
            S_DONE:  if (i_res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // An abort wins over the RUN -> DONE step on the final beat.
        if (abort_w && ((state_q == S_PRIME) || (state_q == S_RUN))) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op_q   <= '0;
            rs1_q  <= '0;
            op_b_q <= '0;
            res_q  <= '0;
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_op_valid) begin
                        op_q   <= i_op;
                        rs1_q  <= i_rs1;
                        op_b_q <= i_op_b;
                        cnt_q  <= '0;
                    end
                end
                S_RUN: begin
                    rs1_q  <= rs1_q >> W;
                    op_b_q <= op_b_q >> W;
                    // Written as shift/or so W == XLEN needs no zero-width slice.
                    res_q  <= (res_q >> W) | (XLEN'(i_alu_rd) << (XLEN - W));
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (last_beat) flag_q <= i_alu_cmp;
                end
                default: ;
            endcase
        end
    end

    // ALU control decode, held constant through PRIME and RUN so the carry
    // register sees the op's carry-in while the ALU is still disabled.
    always_comb begin
        o_alu_sub     = 1'b0;
        o_alu_bool_op = 2'b00;
        o_alu_cmp_eq  = 1'b0;
        o_alu_cmp_sig = 1'b0;
        o_alu_rd_sel  = 3'b000;
        if ((state_q == S_PRIME) || (state_q == S_RUN)) begin
            case (op_q)
                OP_ADD: begin
                    o_alu_rd_sel = 3'b001;
                end
                OP_SUB: begin
                    o_alu_sub    = 1'b1;
                    o_alu_rd_sel = 3'b001;
                end
                OP_SLT: begin
                    o_alu_sub     = 1'b1;
                    o_alu_cmp_sig = 1'b1;
                end
                OP_SLTU: begin
                    o_alu_sub = 1'b1;
                end
                OP_XOR: begin
                    o_alu_rd_sel = 3'b100;
                end
                OP_OR: begin
                    o_alu_bool_op = 2'b10;
                    o_alu_rd_sel  = 3'b100;
                end
                OP_AND: begin
                    o_alu_bool_op = 2'b11;
                    o_alu_rd_sel  = 3'b100;
                end
                OP_EQ: begin
                    o_alu_sub    = 1'b1;
                    o_alu_cmp_eq = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_op_ready  = (state_q == S_IDLE);
    assign o_res_valid = (state_q == S_DONE);
    assign o_alu_en    = (state_q == S_RUN);
    assign o_alu_cnt0  = (state_q == S_RUN) && (cnt_q == '0);
    assign o_alu_rs1   = rs1_q[W-1:0];
    assign o_alu_op_b  = op_b_q[W-1:0];
    assign o_res       = is_cmp ? {{(XLEN-1){1'b0}}, flag_q} : res_q;
    assign o_res_cmp   = is_cmp & flag_q;

endmodule

// File: tb/tb_serv_alu_seq.sv
// Testbench for serv_alu_seq. Contains a behavioural bit-serial ALU that
// answers the sequencer's control outputs, and checks each returned word
// against a word-level arithmetic reference. Build with
// +define+SERV_ALU_SEQ_ABORT_EN to include the abort scenario.

module tb_serv_alu_seq;

    localparam int W    = 1;
    localparam int XLEN = 32;
    localparam int N    = XLEN / W;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            i_op_valid = 1'b0;
    logic            o_op_ready;
    logic [2:0]      i_op = '0;
    logic [XLEN-1:0] i_rs1 = '0;
    logic [XLEN-1:0] i_op_b = '0;
    logic            o_res_valid;
    logic            i_res_ready = 1'b0;
    logic [XLEN-1:0] o_res;
    logic            o_res_cmp;
    logic            o_alu_en;
    logic            o_alu_cnt0;
    logic            o_alu_sub;
    logic [1:0]      o_alu_bool_op;
    logic            o_alu_cmp_eq;
    logic            o_alu_cmp_sig;
    logic [2:0]      o_alu_rd_sel;
    logic [W-1:0]    o_alu_rs1;
    logic [W-1:0]    o_alu_op_b;
    logic [W-1:0]    i_alu_rd;
    logic            i_alu_cmp;
`ifdef SERV_ALU_SEQ_ABORT_EN
    logic            i_abort = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    serv_alu_seq #(.W(W), .XLEN(XLEN)) dut (
`ifdef SERV_ALU_SEQ_ABORT_EN
        .i_abort       (i_abort),
`endif
        .clk           (clk),
        .i_rst_n       (rst_n),
        .i_op_valid    (i_op_valid),
        .o_op_ready    (o_op_ready),
        .i_op          (i_op),
        .i_rs1         (i_rs1),
        .i_op_b        (i_op_b),
        .o_res_valid   (o_res_valid),
        .i_res_ready   (i_res_ready),
        .o_res         (o_res),
        .o_res_cmp     (o_res_cmp),
        .o_alu_en      (o_alu_en),
        .o_alu_cnt0    (o_alu_cnt0),
        .o_alu_sub     (o_alu_sub),
        .o_alu_bool_op (o_alu_bool_op),
        .o_alu_cmp_eq  (o_alu_cmp_eq),
        .o_alu_cmp_sig (o_alu_cmp_sig),
        .o_alu_rd_sel  (o_alu_rd_sel),
        .o_alu_rs1     (o_alu_rs1),
        .o_alu_op_b    (o_alu_op_b),
        .i_alu_rd      (i_alu_rd),
        .i_alu_cmp     (i_alu_cmp)
    );

    always #5 clk = ~clk;

    // Behavioural serial ALU: carry loads i_sub while disabled, equality
    // accumulates from cnt0, less-than is judged from the current beat's MSB.
    logic         cy_r, eq_r, eq_now, lt_s, lt_u;
    logic [W-1:0] bx, bool_v;
    logic [W:0]   sum;

    always_comb begin
        bx     = o_alu_op_b ^ {W{o_alu_sub}};
        sum    = {1'b0, o_alu_rs1} + {1'b0, bx} + {{W{1'b0}}, cy_r};
        eq_now = (o_alu_cnt0 | eq_r) & (sum[W-1:0] == '0);
        lt_s   = (o_alu_rs1[W-1] != o_alu_op_b[W-1]) ? o_alu_rs1[W-1] : sum[W-1];
        lt_u   = ~sum[W];
        case (o_alu_bool_op)
            2'b00:   bool_v = o_alu_rs1 ^ o_alu_op_b;
            2'b10:   bool_v = o_alu_rs1 | o_alu_op_b;
            2'b11:   bool_v = o_alu_rs1 & o_alu_op_b;
            default: bool_v = '0;
        endcase
        i_alu_rd  = o_alu_rd_sel[0] ? sum[W-1:0] : (o_alu_rd_sel[2] ? bool_v : '0);
        i_alu_cmp = o_alu_cmp_eq ? eq_now : (o_alu_cmp_sig ? lt_s : lt_u);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cy_r <= 1'b0;
            eq_r <= 1'b0;
        end else begin
            cy_r <= o_alu_en ? sum[W] : o_alu_sub;
            if (o_alu_en) eq_r <= eq_now;
        end
    end

    logic [7:0] ctrl_obs;
    assign ctrl_obs = {o_alu_sub, o_alu_bool_op, o_alu_cmp_eq, o_alu_cmp_sig, o_alu_rd_sel};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {flag, word}
    function automatic logic [XLEN:0] ref_model(input logic [2:0] op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic f;
        case (op)
            3'd0: return {1'b0, a + b};
            3'd1: return {1'b0, a - b};
            3'd2: begin f = ($signed(a) < $signed(b)); return {f, {(XLEN-1){1'b0}}, f}; end
            3'd3: begin f = (a < b);                   return {f, {(XLEN-1){1'b0}}, f}; end
            3'd4: return {1'b0, a ^ b};
            3'd5: return {1'b0, a | b};
            3'd6: return {1'b0, a & b};
            default: begin f = (a == b); return {f, {(XLEN-1){1'b0}}, f}; end
        endcase
    endfunction

    // {sub, bool_op, cmp_eq, cmp_sig, rd_sel}
    function automatic logic [7:0] exp_ctrl(input logic [2:0] op);
        case (op)
            3'd0: return 8'b0_00_0_0_001;
            3'd1: return 8'b1_00_0_0_001;
            3'd2: return 8'b1_00_0_1_000;
            3'd3: return 8'b1_00_0_0_000;
            3'd4: return 8'b0_00_0_0_100;
            3'd5: return 8'b0_10_0_0_100;
            3'd6: return 8'b0_11_0_0_100;
            default: return 8'b1_00_1_0_000;
        endcase
    endfunction

    // Entered and left at a negedge with the DUT idle. During the operation
    // the command port carries junk with valid high, which must be ignored.
    task automatic run_op(input logic [2:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input int hold);
        logic [XLEN:0] exp_r;
        logic [7:0]    ec;
        int            cyc, k, n_cnt0;
        bit            got;
        exp_r = ref_model(op, a, b);
        ec    = exp_ctrl(op);
        i_op_valid = 1'b1; i_op = op; i_rs1 = a; i_op_b = b; i_res_ready = 1'b0;
        chk("accept_ready", {o_op_ready, o_res_valid}, 2'b10);
        @(posedge clk);
        cyc = 0; n_cnt0 = 0; got = 0;
        while (!got && cyc < 4 * N + 20) begin
            @(negedge clk);
            cyc++;
            if (o_res_valid) begin
                got = 1;
            end else if (cyc == 1) begin
                chk("prime", {o_op_ready, o_alu_en, o_alu_cnt0, ctrl_obs}, {3'b000, ec});
            end else begin
                k = cyc - 2;
                chk("run_beat", {o_op_ready, o_alu_en, o_alu_cnt0, ctrl_obs, o_alu_rs1, o_alu_op_b},
                    {1'b0, 1'b1, (k == 0), ec, a[k*W +: W], b[k*W +: W]});
            end
            if (o_alu_cnt0) n_cnt0++;
            if (cyc == 1) begin
                i_op = 3'($urandom); i_rs1 = $urandom; i_op_b = $urandom;
                i_res_ready = (hold == 0);
            end
        end
        chk("latency", cyc, N + 2);
        chk("cnt0_once", n_cnt0, 1);
        chk("result", {o_res_cmp, o_res}, exp_r);
        chk("done_ctrl", {o_op_ready, o_alu_en, o_alu_cnt0, ctrl_obs}, '0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold", {o_res_valid, o_op_ready, o_res_cmp, o_res}, {1'b1, 1'b0, exp_r});
        end
        i_res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_res_ready = 1'b0;
        i_op_valid  = 1'b0;
        chk("after_handshake", {o_res_valid, o_op_ready}, 2'b01);
    endtask

    logic [2:0]      r_op;
    logic [XLEN-1:0] r_a, r_b;
    bit              seen;

    initial begin
        #3;
        chk("reset_ctrl", {o_op_ready, o_res_valid, o_alu_en, o_alu_cnt0, ctrl_obs,
                           o_alu_rs1, o_alu_op_b, o_res_cmp}, {1'b1, 14'b0});
        chk("reset_res", o_res, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(3'd0, 32'h0000_0005, 32'hFFFF_FFFF, 0);
        run_op(3'd1, 32'h0000_0003, 32'h0000_0005, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op(3'd7, 32'h1234_5678, 32'h1234_5678, 0);
        run_op(3'd7, 32'h1234_5678, 32'h1234_5679, 0);
        run_op(3'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
        run_op(3'd5, 32'h8000_0001, 32'h0F00_0010, 10);
        run_op(3'd4, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 0);

        // Reset during RUN beat 12.
        i_op_valid = 1'b1; i_op = 3'd0; i_rs1 = 32'h0000_00FF; i_op_b = 32'h1;
        @(posedge clk);
        @(negedge clk);
        i_op_valid = 1'b0;
        repeat (13) @(negedge clk);
        chk("pre_reset_run", {o_alu_en, o_alu_cnt0}, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_reset_ctrl", {o_op_ready, o_res_valid, o_alu_en, o_alu_cnt0, ctrl_obs,
                                  o_alu_rs1, o_alu_op_b, o_res_cmp}, {1'b1, 14'b0});
        chk("midrun_reset_res", o_res, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(3'd0, 32'h1, 32'h1, 0);

`ifdef SERV_ALU_SEQ_ABORT_EN
        i_op_valid = 1'b1; i_op = 3'd1; i_rs1 = 32'h55; i_op_b = 32'h22;
        @(posedge clk);
        @(negedge clk);
        i_op_valid = 1'b0;
        repeat (6) @(negedge clk);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        chk("abort_idle", {o_op_ready, o_res_valid, o_alu_en}, 3'b100);
        seen = 0;
        repeat (N + 5) begin
            @(negedge clk);
            if (o_res_valid) seen = 1;
        end
        chk("abort_no_valid", seen, 0);
        run_op(3'd0, 32'h10, 32'h20, 0);
`endif

        for (int i = 0; i < 16; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_b  = ($urandom_range(0, 3) == 0) ? r_a : $urandom;
            run_op(r_op, r_a, r_b, int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
